fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 13 +
 rtl/fq_ring.sv | 59 +++++
 rtl/fetch_queue.sv | 117 +++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared pipeline definitions: fetch FSM encoding and datapath widths.
package fetch_queue_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fq_state_e;

endpackage

// File: rtl/fq_ring.sv
// Circular instruction buffer: storage, read/write pointers and occupancy count.
module fq_ring #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic                   clear,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              do_pop;
  logic              do_push;

  // A push into a full ring is only accepted when the head leaves in the same cycle.
  assign do_pop    = pop && (count != '0);
  assign do_push   = push && ((count != FULL_CNT) || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (ce) begin
      if (clear) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (ce && do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: single-outstanding memory fetch FSM feeding a ring of decoded-ready words.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               deq,
  output logic               inst_valid,
  output logic [INSTR_W-1:0] inst,
  output logic [ADDR_W-1:0]  inst_pc_plus4
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fq_state_e                  state, state_n;
  logic [ADDR_W-1:0]          fetch_pc, fetch_pc_n;
  logic                       mem_req_n;
  logic [ADDR_W-1:0]          mem_addr_n;
  logic                       push;
  logic                       clear;
  logic                       pop;
  logic [CW-1:0]              count;
  logic [INSTR_W+ADDR_W-1:0]  head_data;
  logic                       slot_free;
  logic                       unused_pc_lsb;

  assign slot_free     = count < FULL_CNT;
  assign pop           = deq && inst_valid;
  assign inst_valid    = count != '0;
  assign inst          = head_data[INSTR_W+ADDR_W-1:ADDR_W];
  assign inst_pc_plus4 = head_data[ADDR_W-1:0];
  assign unused_pc_lsb = ^redirect_pc[1:0];

  fq_ring #(
    .DEPTH  (DEPTH),
    .DATA_W (INSTR_W + ADDR_W)
  ) u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .clear     (clear),
    .push      (push),
    .push_data ({mem_rdata, fetch_pc + ADDR_W'(4)}),
    .pop       (pop),
    .head_data (head_data),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
    end else if (ce) begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      mem_req  <= mem_req_n;
      mem_addr <= mem_addr_n;
    end
  end

  // A redirect flushes the ring in every state; an in-flight request is allowed to
  // complete in DISCARD so the bus handshake is never broken.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    mem_req_n  = mem_req;
    mem_addr_n = mem_addr;
    push       = 1'b0;
    clear      = redirect;
    if (redirect) fetch_pc_n = {redirect_pc[ADDR_W-1:2], 2'b00};
    case (state)
      IDLE: begin
        if (!redirect && slot_free) begin
          state_n    = REQ;
          mem_req_n  = 1'b1;
          mem_addr_n = fetch_pc;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_n   = IDLE;
          mem_req_n = 1'b0;
          if (!redirect) begin
            push       = 1'b1;
            fetch_pc_n = fetch_pc + ADDR_W'(4);
          end
        end else if (redirect) begin
          state_n = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_ack) begin
          state_n   = IDLE;
          mem_req_n = 1'b0;
        end
      end
      default: begin
        state_n   = IDLE;
        mem_req_n = 1'b0;
      end
    endcase
  end

endmodule
